// File: rtl/uart_tx_param.sv
// Buffered UART transmitter with run-time frame format (divisor, 5-8 data bits,
// parity, 1/2 stop bits). Bytes queue in a small FIFO and are sent LSB first.
module uart_tx_param #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [1:0]                  data_bits_sel,
  input  logic [1:0]                  parity_mode,
  input  logic                        two_stop,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        Tx_Serial,
  output logic                        Tx_Active,
  output logic                        Tx_Done
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CntW-1:0]  DepthC = CntW'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] MinDiv = DIV_W'(2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push, pop;

  // Frame state
  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       nsel_q, nsel_d;
  logic [1:0]       pmode_q, pmode_d;
  logic             two_stop_q, two_stop_d;
  logic             stop_idx_q, stop_idx_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;

  logic             bit_end;
  logic             par_en;
  logic             par_odd;
  logic [2:0]       last_idx;

  assign in_ready   = count_q < DepthC;
  assign fifo_count = count_q;
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == StIdle) && (count_q != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Contents need no reset: pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign bit_end  = (cnt_q == (div_q - 1'b1));
  assign par_en   = (pmode_q == 2'b01) || (pmode_q == 2'b10);
  assign par_odd  = (pmode_q == 2'b10);
  assign last_idx = 3'd4 + {1'b0, nsel_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    nsel_d     = nsel_q;
    pmode_d    = pmode_q;
    two_stop_d = two_stop_q;
    stop_idx_d = stop_idx_q;
    par_d      = par_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d    = StStart;
          tx_d       = 1'b0;
          cnt_d      = '0;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          par_d      = 1'b0;
          shift_d    = mem_q[rd_ptr_q];
          // Divisors 0 and 1 cannot form a bit period; clamp to 2.
          div_d      = (baud_div < MinDiv) ? MinDiv : baud_div;
          nsel_d     = data_bits_sel;
          pmode_d    = parity_mode;
          two_stop_d = two_stop;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == last_idx) begin
            if (par_en) begin
              state_d = StParity;
              tx_d    = par_q ^ shift_q[0] ^ par_odd;
            end else begin
              state_d    = StStop;
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_q      <= MinDiv;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      nsel_q     <= '0;
      pmode_q    <= '0;
      two_stop_q <= 1'b0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      nsel_q     <= nsel_d;
      pmode_q    <= pmode_d;
      two_stop_q <= two_stop_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign Tx_Serial = tx_q;
  assign Tx_Active = (state_q != StIdle);
  assign Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: per-cycle line/active/done traces are
// compared against hand-derived frame bit patterns.
module tb_uart_tx_param;

  logic        clock;
  logic        reset;
  logic [15:0] baud_div;
  logic [1:0]  data_bits_sel;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [2:0]  fifo_count;
  logic        Tx_Serial;
  logic        Tx_Active;
  logic        Tx_Done;

  int checks = 0;
  int errors = 0;

  logic [127:0] line_r, act_r, done_r;
  int           idx;

  uart_tx_param #(
    .DIV_W      (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .baud_div      (baud_div),
    .data_bits_sel (data_bits_sel),
    .parity_mode   (parity_mode),
    .two_stop      (two_stop),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .fifo_count    (fifo_count),
    .Tx_Serial     (Tx_Serial),
    .Tx_Active     (Tx_Active),
    .Tx_Done       (Tx_Done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [127:0] put_bits(input logic [127:0] v, input logic [15:0] bits,
                                            input int nb, input int d, input int start);
    logic [127:0] r;
    r = v;
    for (int i = 0; i < nb; i++)
      for (int k = 0; k < d; k++) r[start + i * d + k] = bits[i];
    return r;
  endfunction

  function automatic logic [127:0] put_ones(input logic [127:0] v, input int start, input int len);
    logic [127:0] r;
    r = v;
    for (int i = 0; i < len; i++) r[start + i] = 1'b1;
    return r;
  endfunction

  task automatic record_clear();
    line_r = '1;
    act_r  = '0;
    done_r = '0;
    idx    = 0;
  endtask

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      line_r[idx] = Tx_Serial;
      act_r[idx]  = Tx_Active;
      done_r[idx] = Tx_Done;
      idx++;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (Tx_Serial !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", Tx_Serial); end
    checks++;
    if (Tx_Active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", Tx_Active); end
    checks++;
    if (Tx_Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Tx_Done); end
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_8n1();
    logic [127:0] el, ea, ed;
    baud_div = 16'd4; data_bits_sel = 2'd3; parity_mode = 2'd0; two_stop = 1'b0;
    push_byte(8'hA5);
    record_clear();
    record(44);
    // Line bits 0,1,0,1,0,0,1,0,1,1 from edge T+1, each 4 clocks.
    el = put_bits('1, 16'h034A, 10, 4, 1);
    ea = put_ones('0, 1, 40);
    ed = '0; ed[41] = 1'b1;
    checks++;
    if (line_r !== el) begin errors++; $display("FAIL 8n1_line: got %h expected %h", line_r, el); end
    checks++;
    if (act_r !== ea) begin errors++; $display("FAIL 8n1_active: got %h expected %h", act_r, ea); end
    checks++;
    if (done_r !== ed) begin errors++; $display("FAIL 8n1_done: got %h expected %h", done_r, ed); end
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL 8n1_count: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_7o2();
    logic [127:0] el, ea, ed;
    baud_div = 16'd3; data_bits_sel = 2'd2; parity_mode = 2'd2; two_stop = 1'b1;
    push_byte(8'h55);
    record_clear();
    record(36);
    // start 0; data 1,0,1,0,1,0,1; odd parity 1; stops 1,1 -> 33 clocks
    el = put_bits('1, 16'h07AA, 11, 3, 1);
    ea = put_ones('0, 1, 33);
    ed = '0; ed[34] = 1'b1;
    checks++;
    if (line_r !== el) begin errors++; $display("FAIL 7o2_line: got %h expected %h", line_r, el); end
    checks++;
    if (act_r !== ea) begin errors++; $display("FAIL 7o2_active: got %h expected %h", act_r, ea); end
    checks++;
    if (done_r !== ed) begin errors++; $display("FAIL 7o2_done: got %h expected %h", done_r, ed); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] el, ea, ed;
    logic [2:0]   cnt_r [96];
    logic [95:0]  rdy_r;
    logic         rdy;
    logic [7:0]   b;
    logic [15:0]  fb;
    int           acc [6];
    int           exp_acc [6];
    int           n;
    exp_acc = '{0, 1, 2, 3, 4, 17};
    acc     = '{-1, -1, -1, -1, -1, -1};
    baud_div = 16'd2; data_bits_sel = 2'd0; parity_mode = 2'd0; two_stop = 1'b0;
    record_clear();
    n = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 8'h01;
    rdy = in_ready;
    for (int j = 0; j < 96; j++) begin
      @(posedge clock);
      if (rdy && in_valid) begin
        acc[n] = j;
        n++;
        #1;
        if (n < 6) in_data = 8'(n + 1);
        else in_valid = 1'b0;
      end
      @(negedge clock);
      line_r[j] = Tx_Serial;
      act_r[j]  = Tx_Active;
      done_r[j] = Tx_Done;
      cnt_r[j]  = fifo_count;
      rdy_r[j]  = in_ready;
      rdy       = in_ready;
    end
    in_valid = 1'b0;
    // 5N1 at D=2 is 14 clocks; frames start every 15 clocks from edge 1.
    el = '1; ea = '0; ed = '0;
    for (int k = 0; k < 6; k++) begin
      b  = 8'(k + 1);
      fb = {9'b0, 1'b1, b[4:0], 1'b0};
      el = put_bits(el, fb, 7, 2, 1 + 15 * k);
      ea = put_ones(ea, 1 + 15 * k, 14);
      ed[15 + 15 * k] = 1'b1;
    end
    checks++;
    if (line_r !== el) begin errors++; $display("FAIL b2b_line: got %h expected %h", line_r, el); end
    checks++;
    if (act_r !== ea) begin errors++; $display("FAIL b2b_active: got %h expected %h", act_r, ea); end
    checks++;
    if (done_r !== ed) begin errors++; $display("FAIL b2b_done: got %h expected %h", done_r, ed); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (acc[i] !== exp_acc[i]) begin
        errors++;
        $display("FAIL b2b_accept_%0d: got edge %0d expected edge %0d", i, acc[i], exp_acc[i]);
      end
    end
    checks++;
    if (rdy_r[3] !== 1'b1 || cnt_r[3] !== 3'd3) begin
      errors++; $display("FAIL b2b_before_full: got ready %b count %0d expected 1 3", rdy_r[3], cnt_r[3]);
    end
    checks++;
    if (rdy_r[4] !== 1'b0 || cnt_r[4] !== 3'd4) begin
      errors++; $display("FAIL b2b_full: got ready %b count %0d expected 0 4", rdy_r[4], cnt_r[4]);
    end
    checks++;
    if (rdy_r[15] !== 1'b0) begin errors++; $display("FAIL b2b_hold_full: got %b expected 0", rdy_r[15]); end
    checks++;
    if (rdy_r[16] !== 1'b1 || cnt_r[16] !== 3'd3) begin
      errors++; $display("FAIL b2b_after_pop: got ready %b count %0d expected 1 3", rdy_r[16], cnt_r[16]);
    end
    checks++;
    if (cnt_r[17] !== 3'd4) begin errors++; $display("FAIL b2b_refill: got %0d expected 4", cnt_r[17]); end
  endtask

  task automatic test_div_latch();
    logic [127:0] el, ea, ed;
    baud_div = 16'd0; data_bits_sel = 2'd0; parity_mode = 2'd1; two_stop = 1'b0;
    push_byte(8'h13);
    push_byte(8'h13);
    record_clear();
    record(8);
    // Mid-frame change: must only affect the second frame.
    baud_div    = 16'd3;
    parity_mode = 2'd2;
    record(40);
    el = put_bits('1, 16'h00E6, 8, 2, 0);
    el = put_bits(el, 16'h00A6, 8, 3, 17);
    ea = put_ones('0, 0, 16);
    ea = put_ones(ea, 17, 24);
    ed = '0; ed[16] = 1'b1; ed[41] = 1'b1;
    checks++;
    if (line_r !== el) begin errors++; $display("FAIL div_line: got %h expected %h", line_r, el); end
    checks++;
    if (act_r !== ea) begin errors++; $display("FAIL div_active: got %h expected %h", act_r, ea); end
    checks++;
    if (done_r !== ed) begin errors++; $display("FAIL div_done: got %h expected %h", done_r, ed); end
  endtask

  task automatic test_reset_mid();
    baud_div = 16'd4; data_bits_sel = 2'd3; parity_mode = 2'd0; two_stop = 1'b0;
    push_byte(8'h0F);
    push_byte(8'h33);
    push_byte(8'h44);
    record_clear();
    record(6);
    checks++;
    if (fifo_count !== 3'd2 || Tx_Active !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got count %0d active %b expected 2 1", fifo_count, Tx_Active);
    end
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (Tx_Serial !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b expected 1", Tx_Serial); end
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", fifo_count); end
    checks++;
    if (Tx_Active !== 1'b0) begin errors++; $display("FAIL mid_active: got %b expected 0", Tx_Active); end
    checks++;
    if (Tx_Done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b expected 0", Tx_Done); end
    record_clear();
    record(60);
    checks++;
    if (line_r !== '1) begin errors++; $display("FAIL mid_idle_line: got %h expected all ones", line_r); end
    checks++;
    if (act_r !== '0) begin errors++; $display("FAIL mid_idle_active: got %h expected 0", act_r); end
    checks++;
    if (done_r !== '0) begin errors++; $display("FAIL mid_idle_done: got %h expected 0", done_r); end
  endtask

  initial begin
    reset         = 1'b1;
    baud_div      = 16'd4;
    data_bits_sel = 2'd3;
    parity_mode   = 2'd0;
    two_stop      = 1'b0;
    in_valid      = 1'b0;
    in_data       = 8'h00;
    test_reset();
    test_8n1();
    test_7o2();
    test_back_to_back();
    test_div_latch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised, buffered UART transmitter: the next generation of the team's fixed 8N1 transmitter. Accepts bytes over a valid/ready handshake into an internal FIFO and serialises them LSB-first. Frames are programmable at run time: divisor, 5–8 data bits, none/even/odd parity, and 1 or 2 stop bits. Sits between a bus-side register block or DMA and the pad-side TX line.

## Interface
- `DIV_W`, default 16: width of the baud divisor (clocks per bit).
- `FIFO_DEPTH`, default 4: number of byte entries in the FIFO; power of 2, at least 2.
- `clock`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `baud_div`  in  DIV_W  clocks per bit; values 0 and 1 are treated as 2.
- `data_bits_sel`  in  2  data bits per frame = 5 + `data_bits_sel`.
- `parity_mode`  in  2  00 or 11: no parity; 01: even; 10: odd.
- `two_stop`  in  1  0: one stop bit; 1: two stop bits.
- `in_valid`  in  1  producer has a byte on `in_data`.
- `in_data`  in  8  byte to send; only the low N bits are transmitted.
- `in_ready`  out  1  FIFO can accept a byte; high when `fifo_count < FIFO_DEPTH`.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
- `Tx_Serial`  out  1  serial line, registered; idles high.
- `Tx_Active`  out  1  high whenever the FSM is not in IDLE.
- `Tx_Done`  out  1  one-cycle pulse when a frame's final stop bit completes.

## Operation
- **Push:** a byte is accepted on a clock edge when `in_valid && in_ready`. A push while full has no effect. Push and pop on the same edge leave `fifo_count` unchanged.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `Tx_Serial` = 1. If the FIFO is non-empty at the edge, that edge:
  - pops the head entry into the shift register;
  - latches `baud_div`, `data_bits_sel`, `parity_mode` and `two_stop` for the whole frame (mid-frame changes are ignored);
  - moves the FSM to START and drives `Tx_Serial` 0.
- **Bit timing:** each bit lasts exactly D clocks, where D is the latched divisor. A counter runs 0..D-1; the bit advances on the edge where the counter equals D-1.
- **START → DATA:** data bits are sent LSB first; the counter and bit index reset at each transition.
- **DATA → PARITY or STOP:** after N bits, go to PARITY if parity is enabled, else to STOP.
- **Parity bit:** even mode sends the XOR of the N transmitted bits; odd mode sends its inverse.
- **STOP:** `Tx_Serial` = 1 for 1 or 2 bit periods. On the final edge the FSM returns to IDLE and `Tx_Done` is pulsed for one cycle.
- **Back-to-back frames:** if the FIFO is non-empty in that IDLE cycle, the next frame starts on the following edge. Consecutive frames are therefore separated by exactly one extra high clock, and `Tx_Active` is low for exactly that one cycle.
- **Divisor arithmetic:** the counter is DIV_W bits wide with no wrap; the substitution for 0/1 happens at latch time.

## Timing
- **Reset values:** `Tx_Serial`=1, `Tx_Active`=0, `Tx_Done`=0, `fifo_count`=0, `in_ready`=1. FSM goes to IDLE; FIFO pointers clear and contents are discarded.
- **Reset mid-frame:** the line returns high on the reset edge; no `Tx_Done` is produced.
- **Start latency:** a byte accepted at edge T into an empty FIFO while IDLE pops at edge T+1, and `Tx_Serial` falls after T+1.
- **Frame length:** the line spends (1 + N + P + S) × D clocks in the frame, where P ∈ {0,1} and S ∈ {1,2}. `Tx_Done` is high for the single cycle following the last stop-bit edge.
- **Handshake timing:** `in_ready` and `fifo_count` are registered-state functions and reflect pushes and pops from the previous edge. `in_ready` never depends combinationally on `in_valid`.

## Test plan
- **8N1 framing:** reset; `baud_div`=4, `data_bits_sel`=3, `parity_mode`=0, `two_stop`=0; push 0xA5 at edge T. Required:
  - line bits 0,1,0,1,0,0,1,0,1,1, each held 4 clocks, from T+1 to T+41;
  - `Tx_Done` high only in the cycle after T+41;
  - `Tx_Active` high from T+1 to T+41.
- **7O2:** `baud_div`=3, 7 bits, odd parity, two stop bits; send 0x55. Required: 7 data bits 1,0,1,0,1,0,1, then parity 1, then two stop bits; total 33 clocks.
- **Full FIFO and back-to-back:** `FIFO_DEPTH`=4, hold `in_valid` with bytes 0x01..0x06. Required:
  - `in_ready` drops after the fifth accept (one entry already popped);
  - 0x06 is accepted only after the next pop;
  - six frames are sent in order, each separated by exactly one extra high clock.
- **Reset mid-frame:** assert `reset` during a data bit with 2 bytes queued. Required: next cycle `Tx_Serial`=1, `fifo_count`=0, no `Tx_Done`, and no further frames.
- **Divisor edge case and config latching:** `baud_div`=0 gives 2-clock bits. Changing `baud_div` and `parity_mode` mid-frame leaves the current frame unchanged; the next frame uses the new values.
